// File: rtl/sr_cmd_scheduler.sv
// Round-robin scheduler sharing one SR flip-flop cell between N_REQ requesters.
// Each granted command is pulsed for one cycle, settled, then checked against q.
module sr_cmd_scheduler #(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CW         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] cmd,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic [CW-1:0]    grant_id,
  output logic             busy,
  output logic             s,
  output logic             r,
  input  logic             q
);

  // Handshake: a requester raises req[i] with a stable cmd[i] and holds it until
  // it sees the one-cycle ack[i]; it drops req[i] on the edge that samples ack[i].

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      ptr, ptr_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [CW-1:0]      grant_n;
  logic               lcmd, lcmd_n;
  logic               s_n, r_n, err_n, busy_n;
  logic [N_REQ-1:0]   ack_n;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   cmd_sh;
  logic [CW-1:0]      pick;
  logic               found;
  int                 sum;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N_REQ-1:0];
    found   = 1'b0;
    pick    = ptr;
    sum     = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= N_REQ) sum = sum - N_REQ;
        pick  = CW'(sum);
      end
    end
    cmd_sh = cmd >> pick;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant_id;
    lcmd_n  = lcmd;
    s_n     = 1'b0;
    r_n     = 1'b0;
    ack_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          lcmd_n  = cmd_sh[0];
          s_n     = cmd_sh[0];
          r_n     = ~cmd_sh[0];
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        cnt_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          ack_n   = N_REQ'(1) << grant_id;
          err_n   = (q != lcmd);
          state_n = DONE;
        end
      end
      DONE: begin
        ptr_n   = (grant_id == CW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant_id <= '0;
      lcmd     <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      grant_id <= grant_n;
      lcmd     <= lcmd_n;
      s        <= s_n;
      r        <= r_n;
      ack      <= ack_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_sr_cmd_scheduler.sv
// Self-checking bench for sr_cmd_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_sr_cmd_scheduler;
  localparam int N  = 4;
  localparam int SC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  cmd = '0;
  logic [N-1:0]  ack;
  logic          err;
  logic [CW-1:0] grant_id;
  logic          busy, s, r;
  logic          q = 1'b0;
  logic          stuck = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  cmd;
    logic [N-1:0]  ack;
    logic          s;
    logic          r;
    logic          err;
    logic          busy;
    logic [CW-1:0] gid;
  } vec_t;

  vec_t tbl[16];

  // model state
  int   ph, mp, mid;
  logic mcmd;
  logic allow;
  int   k, pp;

  always #5 clk = ~clk;

  sr_cmd_scheduler #(.N_REQ(N), .SETTLE_CYC(SC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .ack(ack), .err(err),
    .grant_id(grant_id), .busy(busy), .s(s), .r(r), .q(q)
  );

  // SR flop cell; stuck forces q low to provoke err
  always @(posedge clk) begin
    if (stuck)  q <= 1'b0;
    else if (s) q <= 1'b1;
    else if (r) q <= 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] rq, input logic [N-1:0] cm,
                              input logic [N-1:0] ak, input logic es, input logic er,
                              input logic ee, input logic eb, input logic [CW-1:0] eg);
    vec_t v;
    v.req = rq; v.cmd = cm; v.ack = ak; v.s = es; v.r = er;
    v.err = ee; v.busy = eb; v.gid = eg;
    return v;
  endfunction

  // Abstract model: one edge of the service timeline, ph = cycles since grant.
  task automatic model_edge();
    logic got;
    if (ph < 0) begin
      if (req != '0) begin
        got = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (!got && req[(mp + j) % N]) begin
            mid = (mp + j) % N;
            got = 1'b1;
          end
        end
        mcmd = cmd[mid];
        ph   = 0;
      end
    end else begin
      ph++;
      if (ph == SC + 2) begin
        ph = -1;
        mp = (mid + 1) % N;
      end
    end
  endtask

  task automatic check_model();
    logic qexp;
    qexp = stuck ? 1'b0 : mcmd;
    chk("rnd_s",    32'(s),        32'(ph == 0 && mcmd));
    chk("rnd_r",    32'(r),        32'(ph == 0 && !mcmd));
    chk("rnd_busy", 32'(busy),     32'(ph >= 0));
    chk("rnd_gid",  32'(grant_id), 32'(mid));
    chk("rnd_ack",  32'(ack),      (ph == SC + 1) ? (32'd1 << mid) : 32'd0);
    chk("rnd_err",  32'(err),      32'(ph == SC + 1 && qexp != mcmd));
  endtask

  always @(negedge clk) begin
    chk("s_and_r",    32'(s & r), 32'd0);
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
  end

  initial begin
    tbl[0]  = mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    tbl[1]  = mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    tbl[2]  = mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    tbl[3]  = mk(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    tbl[4]  = mk(4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    tbl[5]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    tbl[6]  = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    tbl[7]  = mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[8]  = mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[9]  = mk(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[10] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    tbl[11] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[14] = mk(4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

    // Reset held with all requesters asserted: nothing may be driven.
    req = 4'b1111;
    cmd = 4'b0101;
    tick();
    tick();
    chk("rst_s",    32'(s),        32'd0);
    chk("rst_r",    32'(r),        32'd0);
    chk("rst_ack",  32'(ack),      32'd0);
    chk("rst_err",  32'(err),      32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_gid",  32'(grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four held: 5-cycle round-robin 0,1,2,3,0 with set on even ids.
    for (int c = 0; c < 25; c++) begin
      tick();
      k  = c / 5;
      pp = c % 5;
      chk("rr_s",    32'(s),    32'(pp == 0 && (k % 2) == 0));
      chk("rr_r",    32'(r),    32'(pp == 0 && (k % 2) == 1));
      chk("rr_ack",  32'(ack),  (pp == 3) ? (32'd1 << (k % 4)) : 32'd0);
      chk("rr_err",  32'(err),  32'd0);
      chk("rr_busy", 32'(busy), 32'(pp != 4));
      if (pp == 0) chk("rr_gid", 32'(grant_id), 32'(k % 4));
    end
    req = '0;
    tick();
    tick();

    // Directed table: grant after ptr, mid-service cmd change, req drop, idempotent.
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      cmd = tbl[i].cmd;
      tick();
      chk("tbl_s",    32'(s),        32'(tbl[i].s));
      chk("tbl_r",    32'(r),        32'(tbl[i].r));
      chk("tbl_ack",  32'(ack),      32'(tbl[i].ack));
      chk("tbl_err",  32'(err),      32'(tbl[i].err));
      chk("tbl_busy", 32'(busy),     32'(tbl[i].busy));
      chk("tbl_gid",  32'(grant_id), 32'(tbl[i].gid));
    end

    // Stuck-at-0 flop: set command must report err with its ack.
    stuck = 1'b1;
    req = 4'b0010;
    cmd = 4'b0010;
    tick();
    chk("stk_s",   32'(s),        32'd1);
    chk("stk_gid", 32'(grant_id), 32'd1);
    tick();
    tick();
    tick();
    chk("stk_ack", 32'(ack), 32'b0010);
    chk("stk_err", 32'(err), 32'd1);
    req = '0;
    tick();
    chk("stk_busy", 32'(busy), 32'd0);
    chk("stk_ack0", 32'(ack),  32'd0);
    chk("stk_err0", 32'(err),  32'd0);
    stuck = 1'b0;

    // Async reset mid-SETTLE abandons grant 3; re-serve starts from ptr 0.
    req = 4'b1010;
    cmd = 4'b1010;
    tick();
    chk("ar_gid3", 32'(grant_id), 32'd3);
    chk("ar_s",    32'(s),        32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy),     32'd0);
    chk("ar_sr",   32'({s, r}),   32'd0);
    chk("ar_ack",  32'(ack),      32'd0);
    chk("ar_gid0", 32'(grant_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_regid", 32'(grant_id), 32'd1);
    chk("ar_res",   32'(s),        32'd1);
    tick();
    tick();
    tick();
    chk("ar_reack", 32'(ack), 32'b0010);
    req = 4'b1000;
    tick();
    chk("ar_idle", 32'(busy), 32'd0);
    tick();
    chk("ar_next", 32'(grant_id), 32'd3);

    // Randomized run against the transaction model.
    rst = 1'b1;
    req = '0;
    cmd = '0;
    tick();
    tick();
    @(negedge clk);
    rst   = 1'b0;
    ph    = -1;
    mp    = 0;
    mid   = 0;
    mcmd  = 1'b0;
    allow = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c == 1000) allow = 1'b0;
      if (c == 1020) begin
        stuck = 1'b1;
        allow = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if (allow && $urandom_range(0, 3) == 0) cmd[i] = 1'($urandom_range(0, 1));
          else req[i] = 1'b0;
        end else if (!req[i] && allow && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          cmd[i] = 1'($urandom_range(0, 1));
        end
      end
      model_edge();
      tick();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
